// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared definitions for the PS/2 host-to-device transmitter:
//               FSM state encoding, default timing constants, frame geometry,
//               common mouse command bytes and the odd-parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Transmitter FSM states, explicitly encoded in 3 bits.
    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_INHIBIT      = 3'd1,
        ST_REQ_START    = 3'd2,
        ST_SEND_BITS    = 3'd3,
        ST_WAIT_ACK     = 3'd4,
        ST_WAIT_RELEASE = 3'd5
    } ps2_state_t;

    // Default timing at a 100 MHz system clock.
    localparam int unsigned c_inhibit_cycles_def = 12000;    // 120 us
    localparam int unsigned c_timeout_cycles_def = 2000000;  // 20 ms

    // Width of the frame timeout counter (covers the 20 ms default).
    localparam int c_timeout_width = 21;

    // Frame bits shifted out after the start bit: 8 data, parity, stop.
    localparam int c_frame_bits = 10;

    // Common host-to-mouse commands.
    localparam logic [7:0] c_cmd_reset           = 8'hFF;
    localparam logic [7:0] c_cmd_enable_stream   = 8'hF4;
    localparam logic [7:0] c_cmd_set_resolution  = 8'hE8;
    localparam logic [7:0] c_cmd_set_sample_rate = 8'hF3;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : ps2_sync_edge
// Description : Two-flop synchroniser for one asynchronous PS/2 line plus a
//               registered falling-edge detector on the synchronised value.
//               All flops reset to 1 (idle-high bus), so leaving reset never
//               produces a spurious falling edge.
// Ports       : clk     - system clock, rising edge
//               rst_n   - asynchronous active-low reset
//               i_line  - raw asynchronous line sample
//               o_sync  - synchronised line level
//               o_fall  - one-cycle pulse after a 1->0 transition of o_sync
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_sync_edge
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;
    logic r_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_sync_d <= 1'b1;
            r_fall   <= 1'b0;
        end else begin
            r_meta   <= i_line;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            // previous synchronised level 1, current 0
            r_fall   <= r_sync_d & ~r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_fall;

endmodule : ps2_sync_edge
`default_nettype wire

// File: rtl/ps2_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_transmitter
// Description : PS/2 host-to-device byte transmitter. On a SEND_BYTE request
//               in IDLE it inhibits the clock line, issues the start bit,
//               shifts out 8 data bits (LSB first), odd parity and stop on
//               the device-generated clock, then checks the device ACK and
//               waits for the bus to return idle. Reports BYTE_SENT on
//               success and ERROR on missing ACK or frame timeout.
// Parameters  : INHIBIT_CYCLES - CLK cycles the clock line is held low
//               TIMEOUT_CYCLES - CLK cycles allowed from clock release to
//                                ACK completion
// Ports       : CLK               - system clock, rising edge
//               RESET             - asynchronous active-low reset
//               CLK_MOUSE_IN      - raw PS/2 clock line (asynchronous)
//               DATA_MOUSE_IN     - raw PS/2 data line (asynchronous)
//               CLK_MOUSE_OUT_EN  - 1 = pull PS/2 clock low
//               DATA_MOUSE_OUT_EN - 1 = pull PS/2 data low
//               SEND_BYTE         - single-cycle transmit request
//               BYTE_TO_SEND      - byte sampled with SEND_BYTE in IDLE
//               BUSY              - transfer in progress
//               BYTE_SENT         - one-cycle pulse on ACKed transfer
//               ERROR             - one-cycle pulse on no ACK / timeout
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_transmitter
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = c_inhibit_cycles_def,
    parameter int unsigned TIMEOUT_CYCLES = c_timeout_cycles_def
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    output logic       CLK_MOUSE_OUT_EN,
    output logic       DATA_MOUSE_OUT_EN,
    input  logic       SEND_BYTE,
    input  logic [7:0] BYTE_TO_SEND,
    output logic       BUSY,
    output logic       BYTE_SENT,
    output logic       ERROR
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_inh_w = $clog2(INHIBIT_CYCLES + 1);

    // The clock line is low for INHIBIT_CYCLES cycles in total; the final
    // one of those is the REQ_START cycle, where data is also pulled low
    // so the start bit is already on the bus when the clock is released.
    localparam logic [c_inh_w-1:0] c_inh_last =
        c_inh_w'(INHIBIT_CYCLES - 2);

    localparam logic [c_timeout_width-1:0] c_tmo_last =
        c_timeout_width'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] c_last_bit = 4'(c_frame_bits - 1);

    // ------------------------------------------------------------------
    // Line synchronisers
    // ------------------------------------------------------------------
    logic w_clk_sync;
    logic w_clk_fall;
    logic w_data_sync;
    logic w_unused_data_fall;   // data edges carry no meaning for the host

    ps2_sync_edge u_clk_sync (
        .clk    (CLK),
        .rst_n  (RESET),
        .i_line (CLK_MOUSE_IN),
        .o_sync (w_clk_sync),
        .o_fall (w_clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk    (CLK),
        .rst_n  (RESET),
        .i_line (DATA_MOUSE_IN),
        .o_sync (w_data_sync),
        .o_fall (w_unused_data_fall)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    ps2_state_t                 r_state;
    logic [c_frame_bits-1:0]    r_shift;    // {stop, parity, data[7:0]}
    logic [3:0]                 r_bit_cnt;  // falling edges seen in frame
    logic [c_inh_w-1:0]         r_inh_cnt;
    logic [c_timeout_width-1:0] r_tmo;
    logic                       r_clk_en;
    logic                       r_data_en;
    logic                       r_busy;
    logic                       r_sent;
    logic                       r_err;

    logic w_tmo_hit;
    assign w_tmo_hit = (r_tmo == c_tmo_last);

    // ------------------------------------------------------------------
    // Transmitter FSM (all outputs registered)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_inh_cnt <= '0;
            r_tmo     <= '0;
            r_clk_en  <= 1'b0;
            r_data_en <= 1'b0;
            r_busy    <= 1'b0;
            r_sent    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // Status pulses last exactly one cycle.
            r_sent <= 1'b0;
            r_err  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_clk_en  <= 1'b0;
                    r_data_en <= 1'b0;
                    r_busy    <= 1'b0;
                    if (SEND_BYTE) begin
                        r_shift   <= {1'b1, odd_parity(BYTE_TO_SEND),
                                      BYTE_TO_SEND};
                        r_inh_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_clk_en  <= 1'b1;
                        r_state   <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    if (r_inh_cnt == c_inh_last) begin
                        r_data_en <= 1'b1;
                        r_state   <= ST_REQ_START;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + c_inh_w'(1);
                    end
                end

                ST_REQ_START: begin
                    // Release the clock; the device now drives the frame.
                    r_clk_en  <= 1'b0;
                    r_tmo     <= '0;
                    r_bit_cnt <= '0;
                    r_state   <= ST_SEND_BITS;
                end

                ST_SEND_BITS: begin
                    r_tmo <= r_tmo + c_timeout_width'(1);
                    if (w_clk_fall) begin
                        // Present the next frame bit; the stop bit is a 1,
                        // so the data line is released on the last edge.
                        r_data_en <= ~r_shift[0];
                        r_shift   <= {1'b0, r_shift[c_frame_bits-1:1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == c_last_bit) begin
                            r_state <= ST_WAIT_ACK;
                        end
                    end else if (w_tmo_hit) begin
                        r_err     <= 1'b1;
                        r_clk_en  <= 1'b0;
                        r_data_en <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end

                ST_WAIT_ACK: begin
                    r_tmo <= r_tmo + c_timeout_width'(1);
                    if (w_clk_fall) begin
                        if (!w_data_sync) begin
                            r_state <= ST_WAIT_RELEASE;
                        end else begin
                            r_err     <= 1'b1;
                            r_clk_en  <= 1'b0;
                            r_data_en <= 1'b0;
                            r_busy    <= 1'b0;
                            r_state   <= ST_IDLE;
                        end
                    end else if (w_tmo_hit) begin
                        r_err     <= 1'b1;
                        r_clk_en  <= 1'b0;
                        r_data_en <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end

                ST_WAIT_RELEASE: begin
                    r_tmo <= r_tmo + c_timeout_width'(1);
                    // Completion is checked first so it wins over a timeout
                    // landing in the same cycle.
                    if (w_clk_sync && w_data_sync) begin
                        r_sent  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_tmo_hit) begin
                        r_err     <= 1'b1;
                        r_clk_en  <= 1'b0;
                        r_data_en <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end

                default: begin
                    r_clk_en  <= 1'b0;
                    r_data_en <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign CLK_MOUSE_OUT_EN  = r_clk_en;
    assign DATA_MOUSE_OUT_EN = r_data_en;
    assign BUSY              = r_busy;
    assign BYTE_SENT         = r_sent;
    assign ERROR             = r_err;

endmodule : ps2_transmitter
`default_nettype wire
